// File: rtl/temporal_stream_decoder_pkg.sv
// Shared types and default sizing for the temporal (unary) stream decoder.
package temporal_pkg;

  localparam int BIT_WIDTH_DEF  = 4;
  localparam int WINDOW_LEN_DEF = 1 << BIT_WIDTH_DEF;
  localparam int OUT_W_DEF      = BIT_WIDTH_DEF << 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef logic [OUT_W_DEF-1:0] count_t;

endpackage

// File: rtl/temporal_stream_decoder_if.sv
// Stream-side bundle of the decoder: unary sample input plus valid/ready result output.
interface temporal_stream_decoder_if #(
  parameter int DIM   = 2,
  parameter int OUT_W = 8
);

  logic                                  start;
  logic [DIM-1:0][DIM-1:0]               in_bits;
  logic                                  busy;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [DIM-1:0][DIM-1:0][OUT_W-1:0]    out;
  logic [DIM-1:0][DIM-1:0]               err;

  modport master (
    output start, in_bits, out_ready,
    input  busy, out_valid, out, err
  );

  modport slave (
    input  start, in_bits, out_ready,
    output busy, out_valid, out, err
  );

endinterface

// File: rtl/temporal_stream_decoder_lane_counter.sv
// One unary lane: counts ones over a window; optional thermometer check when
// TEMPORAL_DEC_THERM_CHECK_EN is defined (otherwise err is tied low).
module temporal_lane_counter #(
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             bit_in,
  output logic [OUT_W-1:0] count,
  output logic             err
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      count <= '0;
    else if (clear) count <= '0;
    else if (en)    count <= count + OUT_W'(bit_in);
  end

`ifdef TEMPORAL_DEC_THERM_CHECK_EN
  logic seen_zero;

  // A thermometer lane never returns to 1 once a 0 has been sampled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen_zero <= 1'b0;
      err       <= 1'b0;
    end else if (clear) begin
      seen_zero <= 1'b0;
      err       <= 1'b0;
    end else if (en) begin
      if (!bit_in)        seen_zero <= 1'b1;
      else if (seen_zero) err       <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/temporal_stream_decoder.sv
// Unary-to-binary window decoder: DIM x DIM lane counters, window FSM and result registers.
// Optional per-lane thermometer check: TEMPORAL_DEC_THERM_CHECK_EN.
module temporal_stream_decoder
  import temporal_pkg::*;
#(
  parameter int BIT_WIDTH  = BIT_WIDTH_DEF,
  parameter int DIM        = 2,
  parameter int WINDOW_LEN = 1 << BIT_WIDTH,
  parameter int OUT_W      = BIT_WIDTH << 1
) (
  input logic                     clk,
  input logic                     reset,
  temporal_stream_decoder_if.slave bus
);

  localparam int SCNT_W = $clog2(WINDOW_LEN + 1);

  state_t                             state_q, state_d;
  logic [SCNT_W-1:0]                  sample_cnt_q;
  logic                               handshake, win_done;
  logic                               win_start, sample_en, load;
  logic [DIM-1:0][DIM-1:0][OUT_W-1:0] lane_cnt;
  logic [DIM-1:0][DIM-1:0]            lane_err;

  assign handshake = (state_q == HOLD) && bus.out_ready;
  assign win_done  = (sample_cnt_q == SCNT_W'(WINDOW_LEN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = ACCUM;
      ACCUM:   if (win_done)  state_d = HOLD;
      HOLD:    if (handshake) state_d = bus.start ? ACCUM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The extra ACCUM cycle after the last sample is where the result is latched.
  always_comb begin
    bus.busy      = (state_q == ACCUM);
    bus.out_valid = (state_q == HOLD);
    win_start     = bus.start && ((state_q == IDLE) || handshake);
    sample_en     = (state_q == ACCUM) && !win_done;
    load          = (state_q == ACCUM) && win_done;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          sample_cnt_q <= '0;
    else if (win_start) sample_cnt_q <= '0;
    else if (sample_en) sample_cnt_q <= sample_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out <= '0;
      bus.err <= '0;
    end else if (load) begin
      bus.out <= lane_cnt;
      bus.err <= lane_err;
    end
  end

  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      temporal_lane_counter #(.OUT_W(OUT_W)) u_lane (
        .clk    (clk),
        .reset  (reset),
        .clear  (win_start),
        .en     (sample_en),
        .bit_in (bus.in_bits[r][c]),
        .count  (lane_cnt[r][c]),
        .err    (lane_err[r][c])
      );
    end
  end

endmodule

// File: tb/tb_temporal_stream_decoder.sv
// Randomized self-checking bench for temporal_stream_decoder against a window-level reference model.
module tb_temporal_stream_decoder;
  import temporal_pkg::*;

  localparam int DIM   = 2;
  localparam int WL    = 16;
  localparam int OUT_W = 8;
  localparam int NL    = DIM * DIM;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  temporal_stream_decoder_if #(.DIM(DIM), .OUT_W(OUT_W)) bus ();

  temporal_stream_decoder #(
    .BIT_WIDTH  (4),
    .DIM        (DIM),
    .WINDOW_LEN (WL),
    .OUT_W      (OUT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  bit          pat     [NL][WL];
  int          exp_cnt [NL];
  bit          exp_err [NL];
  logic [31:0] exp_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count = popcount; a lane is non-thermometer when it differs from 1^count 0^(WL-count).
  function automatic void model();
    exp_out = '0;
    for (int l = 0; l < NL; l++) begin
      int  cnt = 0;
      bit  e   = 1'b0;
      for (int s = 0; s < WL; s++) cnt += int'(pat[l][s]);
      for (int s = 0; s < WL; s++) if (pat[l][s] != (s < cnt)) e = 1'b1;
      exp_cnt[l] = cnt;
`ifdef TEMPORAL_DEC_THERM_CHECK_EN
      exp_err[l] = e;
`else
      exp_err[l] = 1'b0;
`endif
      exp_out[l*OUT_W +: OUT_W] = OUT_W'(cnt);
    end
  endfunction

  function automatic void set_therm(input int l, input int k);
    for (int s = 0; s < WL; s++) pat[l][s] = (s < k);
  endfunction

  function automatic void set_rand(input int l);
    for (int s = 0; s < WL; s++) pat[l][s] = 1'($urandom_range(0, 1));
  endfunction

  // Called right after the edge that started the window; feeds samples and checks the result.
  task automatic collect();
    int lat = 0;
    for (int k = 1; k <= 40; k++) begin
      for (int l = 0; l < NL; l++)
        bus.in_bits[l/DIM][l%DIM] = (k <= WL) ? pat[l][k-1] : 1'($urandom_range(0, 1));
      bus.start     = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      if (k == 1) check("busy_accum", 32'(bus.busy), 32'd1);
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    check("valid_latency", lat, WL + 1);
    model();
    for (int l = 0; l < NL; l++) begin
      check($sformatf("out[%0d][%0d]", l/DIM, l%DIM), 32'(bus.out[l/DIM][l%DIM]), exp_cnt[l]);
      check($sformatf("err[%0d][%0d]", l/DIM, l%DIM), 32'(bus.err[l/DIM][l%DIM]), 32'(exp_err[l]));
    end
  endtask

  task automatic launch();
    bus.start   = 1'b1;
    bus.in_bits = 4'($urandom);
    tick();
    bus.start   = 1'b0;
    collect();
  endtask

  task automatic release_hold(input bit restart);
    bus.out_ready = 1'b1;
    bus.start     = restart;
    tick();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    check("valid_after_hs", 32'(bus.out_valid), 32'd0);
    check("busy_after_hs", 32'(bus.busy), 32'(restart));
  endtask

  initial begin
    int vcount;
    bit in_hold;

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.in_bits   = '0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_out", bus.out, 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Thermometer lanes
    set_therm(0, 2); set_therm(1, 8); set_therm(2, 12); set_therm(3, 14);
    launch();

    // Stall in HOLD with stray start pulses
    for (int i = 0; i < 5; i++) begin
      bus.out_ready = 1'b0;
      bus.start     = (i == 2);
      tick();
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_out", bus.out, exp_out);
      check("hold_busy", 32'(bus.busy), 32'd0);
    end
    bus.start = 1'b0;
    release_hold(1'b0);
    tick(); tick();
    check("idle_keeps_out", bus.out, exp_out);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // All ones, then back-to-back all zeros
    for (int l = 0; l < NL; l++) set_therm(l, WL);
    launch();
    for (int l = 0; l < NL; l++) set_therm(l, 0);
    release_hold(1'b1);
    collect();
    release_hold(1'b0);

    // Alternating lane 0
    for (int s = 0; s < WL; s++) pat[0][s] = (s % 2 == 0);
    set_therm(1, 5); set_therm(2, 16); set_therm(3, 1);
    launch();
    release_hold(1'b0);

    // Reset in the middle of a window
    for (int l = 0; l < NL; l++) set_rand(l);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int s = 0; s < 7; s++) begin
      for (int l = 0; l < NL; l++) bus.in_bits[l/DIM][l%DIM] = pat[l][s];
      tick();
    end
    #2 reset = 1'b1;
    #1;
    check("midrst_out", bus.out, 32'd0);
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_err", 32'(bus.err), 32'd0);
    tick(); tick();
    reset  = 1'b0;
    vcount = 0;
    for (int i = 0; i < 30; i++) begin
      bus.in_bits   = 4'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      vcount += int'(bus.out_valid);
    end
    bus.out_ready = 1'b0;
    check("no_valid_after_rst", vcount, 0);
    check("idle_after_rst", 32'(bus.busy), 32'd0);

    // Random windows with random idle gaps and back-to-back restarts
    in_hold = 1'b0;
    for (int w = 0; w < 8; w++) begin
      for (int l = 0; l < NL; l++) begin
        if ($urandom_range(0, 2) == 0) set_therm(l, $urandom_range(0, WL));
        else                           set_rand(l);
      end
      if (in_hold && $urandom_range(0, 1) == 1) begin
        release_hold(1'b1);
        collect();
      end else begin
        if (in_hold) release_hold(1'b0);
        repeat ($urandom_range(0, 4)) tick();
        launch();
      end
      in_hold = 1'b1;
      repeat ($urandom_range(0, 3)) begin
        tick();
        check("rand_hold_out", bus.out, exp_out);
      end
    end
    release_hold(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
